// File: rtl/rst_seq_gen.sv
// Reset sequencer: synchronizes a raw asynchronous reset and releases NUM_CH
// active-low channel resets in a fixed, staggered, ascending order.
`timescale 1ns/1ps

module rst_seq_gen #(
    parameter int NUM_CH         = 4,
    parameter int SYNC_STAGES    = 2,
    parameter int RST_CLK_CYCLES = 16,
    parameter int STAGGER_CYCLES = 4,
    parameter int CNT_W          = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              sw_rst_req_i,
    input  logic [NUM_CH-1:0] ch_hold_i,
    output logic [NUM_CH-1:0] rst_no,
    output logic              done_o
);

    localparam longint LAST_SLOT_WIDE =
        longint'(RST_CLK_CYCLES) + longint'(NUM_CH - 1) * longint'(STAGGER_CYCLES);

    // Parameter sanity: refuse to elaborate a configuration the counter cannot time.
    if (NUM_CH < 1) begin : g_chk_num_ch
        $fatal(1, "rst_seq_gen: NUM_CH must be >= 1");
    end
    if (SYNC_STAGES < 2) begin : g_chk_sync
        $fatal(1, "rst_seq_gen: SYNC_STAGES must be >= 2");
    end
    if (RST_CLK_CYCLES < 1) begin : g_chk_rst_cycles
        $fatal(1, "rst_seq_gen: RST_CLK_CYCLES must be >= 1");
    end
    if (STAGGER_CYCLES < 0) begin : g_chk_stagger
        $fatal(1, "rst_seq_gen: STAGGER_CYCLES must be >= 0");
    end
    if (CNT_W < 1 || CNT_W > 62) begin : g_chk_cnt_w
        $fatal(1, "rst_seq_gen: CNT_W must be in 1..62");
    end
    if ((CNT_W <= 62) && (LAST_SLOT_WIDE >= (longint'(1) << CNT_W))) begin : g_chk_cnt_range
        $fatal(1, "rst_seq_gen: last release slot does not fit in CNT_W bits");
    end

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_CLK_CYCLES - 1);
    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(LAST_SLOT_WIDE);

    typedef enum logic [1:0] {
        ST_SYNC,
        ST_HOLD,
        ST_RELEASE,
        ST_RUN
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
    logic [NUM_CH-1:0]   rst_d, release_mask;
    logic                done_d;
    logic [SYNC_STAGES-2:0] sync_q;

    function automatic logic [CNT_W-1:0] slot_of(input int k);
        return CNT_W'(RST_CLK_CYCLES + k * STAGGER_CYCLES);
    endfunction

    // The first SYNC_STAGES-1 stages live here; the state register leaving
    // SYNC is the final stage, so HOLD starts on the SYNC_STAGES-th edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge values regardless of statement order.
            sync_q[0] <= 1'b1;
            for (int i = 1; i < SYNC_STAGES - 1; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_SYNC;
            cnt_q   <= '0;
            rst_no  <= '0;
            done_o  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rst_no  <= rst_d;
            done_o  <= done_d;
        end
    end

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // through the case statement can infer a latch.
        state_d      = state_q;
        cnt_d        = cnt_q;
        rst_d        = rst_no;
        done_d       = done_o;
        cnt_inc      = cnt_q + CNT_W'(1);
        release_mask = '0;

        // A channel leaves reset on the edge where the counter reaches its slot.
        for (int k = 0; k < NUM_CH; k++) begin
            release_mask[k] = (cnt_inc == slot_of(k)) && !ch_hold_i[k];
        end

        case (state_q)
            ST_SYNC: begin
                if (sync_q[SYNC_STAGES-2]) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end
            end
            ST_HOLD: begin
                cnt_d = cnt_inc;
                rst_d = rst_no | release_mask;
                if (cnt_q == HOLD_LAST) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                cnt_d = cnt_inc;
                rst_d = rst_no | release_mask;
                if (cnt_q == LAST_SLOT) begin
                    state_d = ST_RUN;
                    done_d  = 1'b1;
                end
            end
            ST_RUN: begin
                rst_d = ~ch_hold_i;
            end
            default: begin
                state_d = ST_SYNC;
            end
        endcase

        // Software replay wins over everything once the synchronizer has released.
        if (sw_rst_req_i && (state_q != ST_SYNC)) begin
            state_d = ST_HOLD;
            cnt_d   = '0;
            rst_d   = '0;
            done_d  = 1'b0;
        end
    end

endmodule
